// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and the write-port request type for the register-file scoreboard.
package regfile_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Data width carried by wb_req_t; the top casts its DWIDTH ports to and from it.
  localparam int WB_DATA_W  = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard_wb_port_arbiter.sv
// Fixed-priority 2:1 arbiter for the single register-file write port.
// wb0 always wins; a write to x0 is consumed but never enabled.
module wb_port_arbiter
  import regfile_scoreboard_pkg::*;
(
  input  logic    rst,
  input  wb_req_t wb0_i,
  input  wb_req_t wb1_i,
  output logic    wb1_ready_o,
  output logic    regwren_o,
  output wb_req_t sel_o
);

  always_comb begin
    sel_o       = '0;
    wb1_ready_o = 1'b0;
    regwren_o   = 1'b0;
    if (!rst) begin
      wb1_ready_o = ~wb0_i.valid;
      if (wb0_i.valid) begin
        sel_o = wb0_i;
      end else if (wb1_i.valid) begin
        sel_o = wb1_i;
      end
      regwren_o = sel_o.valid & (sel_o.rd != '0);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for long-latency writes: RAW/WAW/capacity/starvation stall
// generation plus arbitration of the register-file write port.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DWIDTH          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid_i,
  input  logic                                 issue_longlat_i,
  input  logic                                 issue_uses_rs1_i,
  input  logic                                 issue_uses_rs2_i,
  input  logic                                 issue_writes_rd_i,
  input  logic [REG_ADDR_W-1:0]                issue_rs1_i,
  input  logic [REG_ADDR_W-1:0]                issue_rs2_i,
  input  logic [REG_ADDR_W-1:0]                issue_rd_i,
  output logic                                 stall_o,
  input  logic                                 wb0_valid_i,
  input  logic [REG_ADDR_W-1:0]                wb0_rd_i,
  input  logic [DWIDTH-1:0]                    wb0_data_i,
  input  logic                                 wb1_valid_i,
  output logic                                 wb1_ready_o,
  input  logic [REG_ADDR_W-1:0]                wb1_rd_i,
  input  logic [DWIDTH-1:0]                    wb1_data_i,
  output logic                                 regwren_o,
  output logic [REG_ADDR_W-1:0]                rd_o,
  output logic [DWIDTH-1:0]                    datawb_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                starve_flag_q, starve_flag_d;
  logic                raw, waw, full, issued, accept, cnt_inc, cnt_dec;
  wb_req_t             wb0_req, wb1_req, sel_req;

  assign wb0_req = '{valid: wb0_valid_i, rd: wb0_rd_i, data: WB_DATA_W'(wb0_data_i)};
  assign wb1_req = '{valid: wb1_valid_i, rd: wb1_rd_i, data: WB_DATA_W'(wb1_data_i)};

  wb_port_arbiter u_arb (
    .rst         (rst),
    .wb0_i       (wb0_req),
    .wb1_i       (wb1_req),
    .wb1_ready_o (wb1_ready_o),
    .regwren_o   (regwren_o),
    .sel_o       (sel_req)
  );

  assign rd_o          = sel_req.rd;
  assign datawb_o      = DWIDTH'(sel_req.data);
  assign outstanding_o = rst ? '0 : count_q;

  // Hazards look only at registered busy bits, so a clear never bypasses into the same cycle.
  always_comb begin
    raw = (issue_uses_rs1_i & (issue_rs1_i != '0) & busy_q[issue_rs1_i]) |
          (issue_uses_rs2_i & (issue_rs2_i != '0) & busy_q[issue_rs2_i]);
    waw = issue_writes_rd_i & (issue_rd_i != '0) & busy_q[issue_rd_i];
    full = issue_longlat_i & (count_q == CW'(MAX_OUTSTANDING));
    stall_o = rst | (issue_valid_i & (raw | waw | full | starve_flag_q));
    issued = issue_valid_i & ~stall_o;
    accept = wb1_valid_i & wb1_ready_o;
  end

  always_comb begin
    busy_d        = busy_q;
    count_d       = count_q;
    starve_cnt_d  = starve_cnt_q;
    starve_flag_d = starve_flag_q;
    cnt_inc       = issued & issue_longlat_i;
    // A return with nothing outstanding is a protocol error; the count saturates at zero.
    cnt_dec       = accept & (count_q != '0);

    if (cnt_inc && !cnt_dec) begin
      count_d = count_q + CW'(1);
    end else if (cnt_dec && !cnt_inc) begin
      count_d = count_q - CW'(1);
    end

    if (accept && (wb1_rd_i != '0)) begin
      busy_d[wb1_rd_i] = 1'b0;
    end
    if (cnt_inc && issue_writes_rd_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end

    if (accept || !wb1_valid_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    if (accept) begin
      starve_flag_d = 1'b0;
    end else if (starve_cnt_d == SW'(STARVE_LIMIT)) begin
      starve_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      count_q       <= '0;
      starve_cnt_q  <= '0;
      starve_flag_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      count_q       <= count_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_flag_q <= starve_flag_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i, issue_longlat_i, issue_uses_rs1_i, issue_uses_rs2_i, issue_writes_rd_i;
  logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic        stall_o;
  logic        wb0_valid_i;
  logic [4:0]  wb0_rd_i;
  logic [31:0] wb0_data_i;
  logic        wb1_valid_i;
  logic        wb1_ready_o;
  logic [4:0]  wb1_rd_i;
  logic [31:0] wb1_data_i;
  logic        regwren_o;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic [2:0]  outstanding_o;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard #(.DWIDTH(32), .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid_i     (issue_valid_i),
    .issue_longlat_i   (issue_longlat_i),
    .issue_uses_rs1_i  (issue_uses_rs1_i),
    .issue_uses_rs2_i  (issue_uses_rs2_i),
    .issue_writes_rd_i (issue_writes_rd_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs2_i       (issue_rs2_i),
    .issue_rd_i        (issue_rd_i),
    .stall_o           (stall_o),
    .wb0_valid_i       (wb0_valid_i),
    .wb0_rd_i          (wb0_rd_i),
    .wb0_data_i        (wb0_data_i),
    .wb1_valid_i       (wb1_valid_i),
    .wb1_ready_o       (wb1_ready_o),
    .wb1_rd_i          (wb1_rd_i),
    .wb1_data_i        (wb1_data_i),
    .regwren_o         (regwren_o),
    .rd_o              (rd_o),
    .datawb_o          (datawb_o),
    .outstanding_o     (outstanding_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    issue_valid_i = 0; issue_longlat_i = 0; issue_uses_rs1_i = 0; issue_uses_rs2_i = 0;
    issue_writes_rd_i = 0; issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
    wb0_valid_i = 0; wb0_rd_i = 0; wb0_data_i = 0;
    wb1_valid_i = 0; wb1_rd_i = 0; wb1_data_i = 0;
  endtask

  task automatic applyStimulus(input logic valid, input logic longlat, input logic uses1,
                               input logic uses2, input logic writes,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    issue_valid_i = valid; issue_longlat_i = longlat; issue_uses_rs1_i = uses1;
    issue_uses_rs2_i = uses2; issue_writes_rd_i = writes;
    issue_rs1_i = rs1; issue_rs2_i = rs2; issue_rd_i = rd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // A wb1 return must never be accepted while nothing is outstanding.
  always @(negedge clk) begin
    if (!rst && wb1_valid_i && wb1_ready_o)
      checkOutput("wb1_accept_with_outstanding", 64'(outstanding_o != 0), 64'd1);
  end

  initial begin
    int drain [4] = '{2, 3, 4, 9};
    rst = 1;
    clearInputs();
    wb1_valid_i = 1; wb1_rd_i = 5; wb1_data_i = 32'h1234;
    nextCycle(); #1;
    checkOutput("rst_stall", stall_o, 1);
    checkOutput("rst_wb1_ready", wb1_ready_o, 0);
    checkOutput("rst_regwren", regwren_o, 0);
    checkOutput("rst_rd", rd_o, 0);
    checkOutput("rst_data", datawb_o, 0);
    checkOutput("rst_outstanding", outstanding_o, 0);
    nextCycle(); rst = 0; clearInputs();

    // RAW hazard against a long-latency load to x5
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 5); #1;
    checkOutput("raw_ld_issue", stall_o, 0);
    nextCycle(); applyStimulus(1, 0, 1, 0, 1, 5, 0, 6); #1;
    checkOutput("raw_stall", stall_o, 1);
    checkOutput("raw_outstanding", outstanding_o, 1);
    nextCycle(); #1;
    checkOutput("raw_stall_hold", stall_o, 1);
    nextCycle(); wb1_valid_i = 1; wb1_rd_i = 5; wb1_data_i = 32'hDEAD_BEEF; #1;
    checkOutput("raw_no_bypass", stall_o, 1);
    checkOutput("raw_wb1_ready", wb1_ready_o, 1);
    checkOutput("raw_regwren", regwren_o, 1);
    checkOutput("raw_rd", rd_o, 5);
    checkOutput("raw_data", datawb_o, 32'hDEAD_BEEF);
    nextCycle(); wb1_valid_i = 0; #1;
    checkOutput("raw_release", stall_o, 0);
    checkOutput("raw_outstanding_0", outstanding_o, 0);
    nextCycle(); clearInputs();

    // Write-port conflict: wb0 wins, wb1 goes the next cycle
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 7); #1;
    checkOutput("port_ld_issue", stall_o, 0);
    nextCycle(); clearInputs();
    wb0_valid_i = 1; wb0_rd_i = 3; wb0_data_i = 32'h11;
    wb1_valid_i = 1; wb1_rd_i = 7; wb1_data_i = 32'h22; #1;
    checkOutput("port_wb0_rd", rd_o, 3);
    checkOutput("port_wb0_data", datawb_o, 32'h11);
    checkOutput("port_wb1_refused", wb1_ready_o, 0);
    checkOutput("port_wb0_wren", regwren_o, 1);
    nextCycle(); wb0_valid_i = 0; #1;
    checkOutput("port_wb1_rd", rd_o, 7);
    checkOutput("port_wb1_data", datawb_o, 32'h22);
    checkOutput("port_wb1_ready", wb1_ready_o, 1);
    nextCycle(); clearInputs(); #1;
    checkOutput("port_outstanding_0", outstanding_o, 0);

    // Capacity: four long-latency ops fill the tracker
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 0, 0, 5'(i)); #1;
      checkOutput("cap_issue", stall_o, 0);
      nextCycle();
    end
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 9); #1;
    checkOutput("cap_outstanding_4", outstanding_o, 4);
    checkOutput("cap_full_stall", stall_o, 1);
    nextCycle(); wb1_valid_i = 1; wb1_rd_i = 1; wb1_data_i = 32'h100; #1;
    checkOutput("cap_stall_during_accept", stall_o, 1);
    checkOutput("cap_wb1_ready", wb1_ready_o, 1);
    nextCycle(); wb1_valid_i = 0; #1;
    checkOutput("cap_issue_after_accept", stall_o, 0);
    checkOutput("cap_outstanding_3", outstanding_o, 3);
    nextCycle(); clearInputs(); #1;
    checkOutput("cap_outstanding_again_4", outstanding_o, 4);
    for (int i = 0; i < 4; i++) begin
      wb1_valid_i = 1; wb1_rd_i = 5'(drain[i]); wb1_data_i = 32'(drain[i]); #1;
      checkOutput("cap_drain_wren", regwren_o, 1);
      nextCycle();
    end
    clearInputs(); #1;
    checkOutput("cap_drained", outstanding_o, 0);

    // Starvation: wb1 refused for eight cycles forces a stall
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 10); #1;
    checkOutput("starve_ld_issue", stall_o, 0);
    nextCycle(); applyStimulus(1, 0, 1, 0, 1, 2, 0, 11);
    wb0_valid_i = 1; wb0_rd_i = 8; wb0_data_i = 32'h80;
    wb1_valid_i = 1; wb1_rd_i = 10; wb1_data_i = 32'hA0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      checkOutput("starve_pre_limit", stall_o, 0);
      nextCycle();
    end
    #1;
    checkOutput("starve_stall", stall_o, 1);
    checkOutput("starve_refused", wb1_ready_o, 0);
    nextCycle(); wb0_valid_i = 0; #1;
    checkOutput("starve_stall_hold", stall_o, 1);
    checkOutput("starve_accept_ready", wb1_ready_o, 1);
    checkOutput("starve_accept_rd", rd_o, 10);
    checkOutput("starve_accept_data", datawb_o, 32'hA0);
    nextCycle(); wb1_valid_i = 0; #1;
    checkOutput("starve_cleared", stall_o, 0);
    checkOutput("starve_outstanding_0", outstanding_o, 0);
    nextCycle(); clearInputs();

    // x0 handling on both write paths and on issue
    wb0_valid_i = 1; wb0_rd_i = 0; wb0_data_i = 32'hFFFF_FFFF;
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0); #1;
    checkOutput("x0_wb0_no_wren", regwren_o, 0);
    checkOutput("x0_ld_issue", stall_o, 0);
    nextCycle(); clearInputs(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0); #1;
    checkOutput("x0_read_no_stall", stall_o, 0);
    checkOutput("x0_outstanding_1", outstanding_o, 1);
    nextCycle(); clearInputs(); wb1_valid_i = 1; wb1_rd_i = 0; wb1_data_i = 32'h5; #1;
    checkOutput("x0_wb1_ready", wb1_ready_o, 1);
    checkOutput("x0_wb1_no_wren", regwren_o, 0);
    nextCycle(); clearInputs(); #1;
    checkOutput("x0_outstanding_0", outstanding_o, 0);

    // Reset in the middle of outstanding work
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 6); #1;
    checkOutput("mrst_ld6", stall_o, 0);
    nextCycle(); applyStimulus(1, 1, 0, 0, 1, 0, 0, 12); #1;
    checkOutput("mrst_ld12", stall_o, 0);
    nextCycle(); applyStimulus(1, 0, 1, 0, 0, 6, 0, 0); #1;
    checkOutput("mrst_raw_stall", stall_o, 1);
    checkOutput("mrst_outstanding_2", outstanding_o, 2);
    nextCycle(); rst = 1; wb0_valid_i = 1; wb0_rd_i = 4; wb0_data_i = 32'h44; #1;
    checkOutput("mrst_stall", stall_o, 1);
    checkOutput("mrst_regwren", regwren_o, 0);
    checkOutput("mrst_rd", rd_o, 0);
    checkOutput("mrst_data", datawb_o, 0);
    checkOutput("mrst_wb1_ready", wb1_ready_o, 0);
    checkOutput("mrst_outstanding", outstanding_o, 0);
    nextCycle(); rst = 0; wb0_valid_i = 0; #1;
    checkOutput("mrst_read_x6_free", stall_o, 0);
    checkOutput("mrst_outstanding_after", outstanding_o, 0);
    nextCycle(); clearInputs();
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
